// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction-fetch front end.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] c_RESET_PC = 32'hbfc00000;
    localparam logic [31:0] c_PC_STEP  = 32'd4;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_unit_if.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit_if
// Brief    : Redirect, instruction-SRAM and decode-side signals of fetch_unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    // master = the fetch unit, slave = its environment (core + SRAM)
    modport master (
        input  redirect_valid, redirect_pc,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  out_ready,
        output inst_req, inst_addr,
        output out_valid, out_pc, out_inst
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output out_ready,
        input  inst_req, inst_addr,
        input  out_valid, out_pc, out_inst
    );

endinterface : fetch_unit_if

`default_nettype wire

// File: rtl/fetch_fifo.sv
//------------------------------------------------------------------------------
// Module   : fetch_fifo
// Brief    : Synchronous FIFO with flush and occupancy count, generic entry type.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       flush,
    input  wire logic                       push,
    input  wire T                           push_data,
    input  wire logic                       pop,
    output      T                           head,
    output      logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_pop  = pop && !flush && (r_count != '0);
    assign w_do_push = push && !flush && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_do_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= push_data;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule : fetch_fifo

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit
// Brief    : Pipelined instruction fetch with credit-based issue and redirect flush.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = c_RESET_PC,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    fetch_unit_if.master bus
);

    localparam int OCW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int QCW   = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = QCW + 3;

    logic [31:0]    r_pc;
    logic [OCW-1:0] r_discard;

    logic [OCW-1:0]   w_outstanding;
    logic [OCW-1:0]   w_outstanding_next;
    logic [OCW-1:0]   w_live;
    logic [QCW-1:0]   w_occupancy;
    logic [SUM_W-1:0] w_reserved;
    logic             w_accept;
    logic             w_resp;
    logic             w_keep;
    logic             w_pop;
    logic [31:0]      w_resp_pc;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;

    // Live responses already own a FIFO slot, so a new request needs one more
    assign w_live     = w_outstanding - r_discard;
    assign w_reserved = SUM_W'(w_occupancy) + SUM_W'(w_live);

    assign bus.inst_req  = !rst
                        && (w_outstanding < OCW'(MAX_OUTSTANDING))
                        && (w_reserved < SUM_W'(FIFO_DEPTH));
    assign bus.inst_addr = r_pc;

    assign w_accept = bus.inst_req && bus.inst_addr_ok;
    assign w_resp   = bus.inst_data_ok && (w_outstanding != '0);
    assign w_keep   = w_resp && (r_discard == '0) && !bus.redirect_valid;
    assign w_pop    = bus.out_valid && bus.out_ready && !bus.redirect_valid;

    assign w_outstanding_next = w_outstanding + OCW'(w_accept) - OCW'(w_resp);

    assign w_push_entry.pc   = w_resp_pc;
    assign w_push_entry.inst = bus.inst_rdata;

    fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (logic [31:0])
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (w_accept),
        .push_data (r_pc),
        .pop       (w_resp),
        .head      (w_resp_pc),
        .count     (w_outstanding)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (w_keep),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_occupancy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pc <= RESET_PC;
        else if (bus.redirect_valid)
            r_pc <= {bus.redirect_pc[31:2], 2'b00};
        else if (w_accept)
            r_pc <= r_pc + c_PC_STEP;
    end

    // Everything still in flight after a redirect belongs to the old stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_discard <= '0;
        else if (bus.redirect_valid)
            r_discard <= w_outstanding_next;
        else if (w_resp && (r_discard != '0))
            r_discard <= r_discard - OCW'(1);
    end

    assign bus.out_valid = (w_occupancy != '0);
    assign bus.out_pc    = bus.out_valid ? w_head.pc   : 32'h0;
    assign bus.out_inst  = bus.out_valid ? w_head.inst : 32'h0;

    a_resp_has_request: assert property (
        @(posedge clk) disable iff (rst) !(bus.inst_data_ok && (w_outstanding == '0))
    );

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit with an SRAM model and scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC        (RST_PC),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    pend_t        pend_q[$];
    fetch_entry_t exp_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_acc;
    int          n_pop;
    bit          resp_en;
    bit          popped;
    logic [31:0] popped_pc;
    logic [31:0] exp_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3c5a96e1;
    endfunction

    task automatic model_clear();
        pend_q.delete();
        exp_q.delete();
        exp_pc = RST_PC;
    endtask

    // One clock: SRAM model drives the response, scoreboard updates, then the edge
    task automatic tick();
        bit           acc;
        bit           dok;
        pend_t        e;
        fetch_entry_t x;
        dok = resp_en && !rst && (pend_q.size() > 0);
        bus.inst_data_ok = dok;
        bus.inst_rdata   = dok ? mem_data(pend_q[0].addr) : 32'h0;
        #1;
        acc    = bus.inst_req && bus.inst_addr_ok;
        popped = 1'b0;
        if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            n_tests++;
            popped    = 1'b1;
            popped_pc = bus.out_pc;
            n_pop++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got pc=%h inst=%h, expected no output", bus.out_pc, bus.out_inst);
            end else begin
                x = exp_q.pop_front();
                if (bus.out_pc !== x.pc || bus.out_inst !== x.inst) begin
                    n_fail++;
                    $display("FAIL out_data: got pc=%h inst=%h, expected pc=%h inst=%h",
                             bus.out_pc, bus.out_inst, x.pc, x.inst);
                end
            end
        end
        if (acc) begin
            n_tests++;
            n_acc++;
            if (bus.inst_addr !== exp_pc) begin
                n_fail++;
                $display("FAIL req_addr: got %h, expected %h", bus.inst_addr, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
        if (dok) begin
            e = pend_q.pop_front();
            if (!e.stale && !bus.redirect_valid)
                exp_q.push_back('{pc: e.addr, inst: mem_data(e.addr)});
        end
        if (acc)
            pend_q.push_back('{addr: bus.inst_addr, stale: 1'b0});
        if (bus.redirect_valid) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            exp_pc = {bus.redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_addr_ok   = 1'b0;
        bus.inst_data_ok   = 1'b0;
        bus.inst_rdata     = 32'h0;
        bus.out_ready      = 1'b0;
        resp_en            = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_addr_ok   = 1'b1;
        bus.inst_data_ok   = 1'b0;
        bus.inst_rdata     = 32'h0;
        bus.out_ready      = 1'b1;
        resp_en            = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        n_tests += 5;
        if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b, expected 0", bus.inst_req); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", bus.out_valid); end
        if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_out_pc: got %h, expected 0", bus.out_pc); end
        if (bus.out_inst !== 32'h0) begin n_fail++; $display("FAIL rst_out_inst: got %h, expected 0", bus.out_inst); end
        if (bus.inst_addr !== RST_PC) begin n_fail++; $display("FAIL rst_pc: got %h, expected %h", bus.inst_addr, RST_PC); end
        rst = 1'b0;
        #1;
        n_tests += 2;
        if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL rel_req: got %b, expected 1", bus.inst_req); end
        if (bus.inst_addr !== RST_PC) begin n_fail++; $display("FAIL rel_addr: got %h, expected %h", bus.inst_addr, RST_PC); end
    endtask

    task automatic test_stream();
        apply_reset();
        bus.inst_addr_ok = 1'b1;
        bus.out_ready    = 1'b1;
        resp_en          = 1'b1;
        tick();
        tick();
        n_pop = 0;
        repeat (16) tick();
        n_tests++;
        if (n_pop !== 16) begin n_fail++; $display("FAIL stream_rate: got %0d pops, expected 16", n_pop); end
    endtask

    task automatic test_back_pressure();
        apply_reset();
        bus.inst_addr_ok = 1'b1;
        bus.out_ready    = 1'b0;
        resp_en          = 1'b1;
        n_acc = 0;
        repeat (10) tick();
        n_tests += 3;
        if (n_acc !== 4) begin n_fail++; $display("FAIL bp_accepts: got %0d, expected 4", n_acc); end
        if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %b, expected 0", bus.inst_req); end
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, expected 1", bus.out_valid); end
        bus.out_ready = 1'b1;
        n_acc = 0;
        n_pop = 0;
        repeat (10) tick();
        n_tests += 2;
        if (n_pop !== 10) begin n_fail++; $display("FAIL bp_drain: got %0d pops, expected 10", n_pop); end
        if (n_acc !== 9) begin n_fail++; $display("FAIL bp_resume: got %0d accepts, expected 9", n_acc); end
    endtask

    task automatic test_addr_stall();
        apply_reset();
        bus.inst_addr_ok = 1'b1;
        bus.out_ready    = 1'b1;
        resp_en          = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        repeat (3) begin
            tick();
            n_tests++;
            if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00004) begin
                n_fail++;
                $display("FAIL stall_hold: got req=%b addr=%h, expected req=1 addr=bfc00004", bus.inst_req, bus.inst_addr);
            end
        end
        bus.inst_addr_ok = 1'b1;
        tick();
        n_tests++;
        if (bus.inst_addr !== 32'hbfc00008) begin n_fail++; $display("FAIL stall_advance: got %h, expected bfc00008", bus.inst_addr); end
        repeat (4) tick();
    endtask

    task automatic test_redirect();
        bit seen;
        apply_reset();
        bus.inst_addr_ok = 1'b1;
        bus.out_ready    = 1'b1;
        resp_en          = 1'b0;
        tick();
        tick();
        n_tests++;
        if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL redir_full: got req=%b, expected 0", bus.inst_req); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80001002;
        tick();
        bus.redirect_valid = 1'b0;
        n_tests++;
        if (bus.inst_addr !== 32'h80001000) begin n_fail++; $display("FAIL redir_addr: got %h, expected 80001000", bus.inst_addr); end
        resp_en = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = popped;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL redir_timeout: got no output in 20 cycles, expected pc 80001000");
        end else if (popped_pc !== 32'h80001000) begin
            n_fail++;
            $display("FAIL redir_first_pc: got %h, expected 80001000", popped_pc);
        end
        repeat (4) tick();
    endtask

    task automatic test_redirect_same_cycle();
        bit seen;
        apply_reset();
        bus.inst_addr_ok = 1'b1;
        bus.out_ready    = 1'b1;
        resp_en          = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (!(bus.inst_req === 1'b1 && pend_q.size() > 0)) begin
            n_fail++;
            $display("FAIL same_setup: got req=%b pending=%0d, expected req=1 pending>0", bus.inst_req, pend_q.size());
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00002000;
        tick();
        bus.redirect_valid = 1'b0;
        n_tests++;
        if (bus.inst_addr !== 32'h00002000) begin n_fail++; $display("FAIL same_addr: got %h, expected 00002000", bus.inst_addr); end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = popped;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL same_timeout: got no output in 20 cycles, expected pc 00002000");
        end else if (popped_pc !== 32'h00002000) begin
            n_fail++;
            $display("FAIL same_first_pc: got %h, expected 00002000", popped_pc);
        end
        repeat (6) tick();
    endtask

    task automatic test_wrap_and_reset();
        apply_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hfffffffc;
        tick();
        bus.redirect_valid = 1'b0;
        bus.inst_addr_ok   = 1'b1;
        bus.out_ready      = 1'b1;
        resp_en            = 1'b1;
        n_tests++;
        if (bus.inst_addr !== 32'hfffffffc) begin n_fail++; $display("FAIL wrap_start: got %h, expected fffffffc", bus.inst_addr); end
        tick();
        n_tests++;
        if (bus.inst_addr !== 32'h00000000) begin n_fail++; $display("FAIL wrap_addr: got %h, expected 00000000", bus.inst_addr); end
        repeat (5) tick();
        rst = 1'b1;
        bus.inst_data_ok = 1'b0;
        #1;
        model_clear();
        n_tests += 2;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, expected 0", bus.out_valid); end
        if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b, expected 0", bus.inst_req); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests += 2;
        if (bus.inst_addr !== RST_PC) begin n_fail++; $display("FAIL midrst_addr: got %h, expected %h", bus.inst_addr, RST_PC); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rel_valid: got %b, expected 0", bus.out_valid); end
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_addr_stall();
        test_redirect();
        test_redirect_same_cycle();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fetch_unit

`default_nettype wire
